// File: rtl/accel_pkg.sv
// Shared types and register map for the accelerometer sequencer.
package accel_pkg;

  typedef enum logic [2:0] {
    INIT,
    WAIT_TICK,
    READ,
    UPDATE,
    ERR
  } state_t;

  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [2:0] LAST_CFG_IDX  = 3'd2;
  localparam logic [2:0] LAST_READ_IDX = 3'd5;

  // Data registers are read low byte first, X then Y then Z.
  function automatic logic [5:0] read_addr(input logic [2:0] idx);
    logic [5:0] addr;
    case (idx)
      3'd0:    addr = ADDR_DATAX0;
      3'd1:    addr = ADDR_DATAX1;
      3'd2:    addr = ADDR_DATAY0;
      3'd3:    addr = ADDR_DATAY1;
      3'd4:    addr = ADDR_DATAZ0;
      default: addr = ADDR_DATAZ1;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/accel_sequencer.sv
// Configures the accelerometer over an external SPI byte engine, then reads X/Y/Z per sample_tick.
// Optional ACK timeout with sticky error is built only when ACCEL_SEQ_TIMEOUT_EN is defined.
module accel_sequencer
  import accel_pkg::*;
#(
  parameter logic [7:0] DATA_FORMAT_VAL = 8'h0B,
  parameter logic [7:0] BW_RATE_VAL     = 8'h0A,
  parameter logic [7:0] POWER_CTL_VAL   = 8'h08,
  parameter int         TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  output logic        spi_req,
  output logic        spi_wr,
  output logic [5:0]  spi_addr,
  output logic [7:0]  spi_wdata,
  input  logic        spi_ack,
  input  logic [7:0]  spi_rdata,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic [15:0] data_z,
  output logic        data_valid,
  output logic        init_done,
  output logic        overrun,
  output logic        err
);

  state_t      state_q;
  logic [2:0]  idx_q;
  logic        req_q;
  logic        wr_q;
  logic [5:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  byte_q [5];
  logic [15:0] dataX_q;
  logic [15:0] dataY_q;
  logic [15:0] dataZ_q;
  logic        dataValid_q;
  logic        initDone_q;
  logic [5:0]  cfgAddr_d;
  logic [7:0]  cfgData_d;

`ifdef ACCEL_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] waitCnt_q;
  logic              err_q;
`endif

  always_comb begin
    cfgAddr_d = ADDR_DATA_FORMAT;
    cfgData_d = DATA_FORMAT_VAL;
    case (idx_q)
      3'd1: begin
        cfgAddr_d = ADDR_BW_RATE;
        cfgData_d = BW_RATE_VAL;
      end
      3'd2: begin
        cfgAddr_d = ADDR_POWER_CTL;
        cfgData_d = POWER_CTL_VAL;
      end
      default: ;
    endcase
  end

  // A request is raised only from a cycle where req is low, which guarantees
  // the one-cycle gap after every ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      idx_q       <= '0;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      for (int i = 0; i < 5; i++) byte_q[i] <= '0;
      dataX_q     <= '0;
      dataY_q     <= '0;
      dataZ_q     <= '0;
      dataValid_q <= 1'b0;
      initDone_q  <= 1'b0;
`ifdef ACCEL_SEQ_TIMEOUT_EN
      waitCnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      dataValid_q <= 1'b0;
      unique case (state_q)
        INIT: begin
          if (!req_q) begin
            req_q   <= 1'b1;
            wr_q    <= 1'b1;
            addr_q  <= cfgAddr_d;
            wdata_q <= cfgData_d;
          end else if (spi_ack) begin
            req_q <= 1'b0;
            if (idx_q == LAST_CFG_IDX) begin
              idx_q      <= '0;
              initDone_q <= 1'b1;
              state_q    <= WAIT_TICK;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        WAIT_TICK: begin
          if (sample_tick) begin
            idx_q   <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          if (!req_q) begin
            req_q   <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= read_addr(idx_q);
            wdata_q <= 8'h00;
          end else if (spi_ack) begin
            req_q <= 1'b0;
            // The last byte goes straight into Z so all three axes load together.
            if (idx_q == LAST_READ_IDX) begin
              dataX_q     <= {byte_q[1], byte_q[0]};
              dataY_q     <= {byte_q[3], byte_q[2]};
              dataZ_q     <= {spi_rdata, byte_q[4]};
              dataValid_q <= 1'b1;
              idx_q       <= '0;
              state_q     <= UPDATE;
            end else begin
              byte_q[idx_q] <= spi_rdata;
              idx_q         <= idx_q + 3'd1;
            end
          end
        end
        UPDATE:  state_q <= WAIT_TICK;
        ERR:     ;
        default: state_q <= INIT;
      endcase
`ifdef ACCEL_SEQ_TIMEOUT_EN
      if (req_q && !spi_ack) begin
        if (waitCnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          req_q     <= 1'b0;
          err_q     <= 1'b1;
          state_q   <= ERR;
          waitCnt_q <= '0;
        end else begin
          waitCnt_q <= waitCnt_q + 1'b1;
        end
      end else begin
        waitCnt_q <= '0;
      end
`endif
    end
  end

  assign spi_req    = req_q;
  assign spi_wr     = wr_q;
  assign spi_addr   = addr_q;
  assign spi_wdata  = wdata_q;
  assign data_x     = dataX_q;
  assign data_y     = dataY_q;
  assign data_z     = dataZ_q;
  assign data_valid = dataValid_q;
  assign init_done  = initDone_q;
  assign overrun    = sample_tick & ~rst &
                      ((state_q == INIT) | (state_q == READ) | (state_q == UPDATE));

`ifdef ACCEL_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/accel_sequencer.md
ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

Interface
REQ-001 SHALL have parameter DATA_FORMAT_VAL, default 8'h0B, value written to register 0x31.
REQ-002 SHALL have parameter BW_RATE_VAL, default 8'h0A, value written to register 0x2C.
REQ-003 SHALL have parameter POWER_CTL_VAL, default 8'h08, value written to register 0x2D.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum number of cycles that spi_req may wait for spi_ack.
REQ-005 SHALL have the port clk, input, 1 bit: the single clock.
REQ-006 SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have the port sample_tick, input, 1 bit: one-cycle strobe that requests one X/Y/Z read.
REQ-008 SHALL have the port spi_req, output, 1 bit: transaction request to the byte-level SPI engine.
REQ-009 SHALL have the port spi_wr, output, 1 bit: 1 means register write, 0 means register read.
REQ-010 SHALL have the port spi_addr, output, 6 bits: register address.
REQ-011 SHALL have the port spi_wdata, output, 8 bits: write byte.
REQ-012 SHALL have the port spi_ack, input, 1 bit: transaction complete.
REQ-013 SHALL have the port spi_rdata, input, 8 bits: read byte, valid while spi_ack is high.
REQ-014 SHALL have the ports data_x, data_y and data_z, each an output of 16 bits: the last complete sample, {DATA1,DATA0}.
REQ-015 SHALL have the port data_valid, output, 1 bit: one-cycle pulse when new data is available.
REQ-016 SHALL have the port init_done, output, 1 bit: high once the configuration writes are complete.
REQ-017 SHALL have the port overrun, output, 1 bit: one-cycle pulse when a sample_tick is dropped.
REQ-018 SHALL have the port err, output, 1 bit: sticky timeout error.

Function
REQ-019 SHALL implement the states INIT, WAIT_TICK, READ, UPDATE and ERR.
REQ-020 INIT SHALL issue three writes in this order: 0x31←DATA_FORMAT_VAL, 0x2C←BW_RATE_VAL, 0x2D←POWER_CTL_VAL; after the third ack the block SHALL go to WAIT_TICK and set init_done.
REQ-021 In WAIT_TICK, a sample_tick SHALL cause a move to READ on the next cycle.
REQ-022 READ SHALL issue six single-byte reads, addresses 0x32 through 0x37 in ascending order, and capture spi_rdata into internal byte registers on each ack.
REQ-023 After the sixth ack the block SHALL enter UPDATE; in UPDATE, data_x, data_y and data_z SHALL load together and data_valid SHALL pulse, 1 cycle after the final ack.
REQ-024 UPDATE SHALL return to WAIT_TICK after 1 cycle.
REQ-025 Handshake: spi_req, spi_wr, spi_addr and spi_wdata SHALL remain stable while spi_req is high and spi_ack is low.
REQ-026 spi_req SHALL drop in the cycle after ack is sampled.
REQ-027 At least one cycle with spi_req low SHALL separate consecutive requests.
REQ-028 spi_ack SHALL be ignored while spi_req is low.
REQ-029 spi_wdata SHALL be 8'h00 during reads.
REQ-030 A sample_tick in INIT, READ or UPDATE SHALL be dropped and SHALL produce an overrun pulse in the same cycle as the tick; ticks SHALL NOT be queued.
REQ-031 Outputs SHALL NOT change outside UPDATE, so a partial read never alters data_x, data_y or data_z.

Reset
REQ-032 While rst is high, the state SHALL be INIT with the transaction index at 0.
REQ-033 While rst is high, spi_req, data_valid, init_done, overrun and err SHALL be 0, and data_x, data_y and data_z SHALL be 16'h0000.
REQ-034 An rst asserted mid-transaction SHALL drop spi_req immediately, and the sequence SHALL restart from INIT after release.

Configuration
REQ-035 With ACCEL_SEQ_TIMEOUT_EN defined, a wait counter SHALL run while spi_req is high and spi_ack is low.
REQ-036 When the wait counter reaches TIMEOUT_CYCLES, spi_req SHALL drop, err SHALL set, and the block SHALL enter ERR.
REQ-037 ERR SHALL be left only by rst.
REQ-038 Without ACCEL_SEQ_TIMEOUT_EN, the block SHALL wait indefinitely for ack, err SHALL be tied to 0, the ERR state SHALL be unreachable, and no counter logic SHALL be built.

Structure
REQ-039 A shared package accel_pkg SHALL hold the state enum and the register address constants 0x2C, 0x2D, 0x31 and 0x32–0x37.
REQ-040 The block SHALL be a single module with no sub-module; the SPI byte engine SHALL be external.

Verification
REQ-041 Bench responder with 2-cycle ack latency → after reset, exactly 3 writes in the order (0x31,0x0B), (0x2C,0x0A), (0x2D,0x08), then init_done=1.
REQ-042 sample_tick with rdata sequence 0x11,0x22,0x33,0x44,0x55,0x66 → data_x=16'h2211, data_y=16'h4433, data_z=16'h6655, and data_valid high for 1 cycle, 1 cycle after the sixth ack.
REQ-043 Second tick during READ → overrun pulse, only 6 reads total, no second data_valid.
REQ-044 rst asserted mid-READ after 3 acks → spi_req=0 immediately, data outputs=0, and INIT writes repeat after release.
REQ-045 With ACCEL_SEQ_TIMEOUT_EN and the ack withheld → err=1 after 1024 cycles of spi_req, spi_req=0, and later ticks are ignored; without the macro, spi_req stays high indefinitely.
REQ-046 Responder with spi_ack asserted while spi_req is low, plus variable 1–5 cycle latency → address and data stable until ack, and a ≥1-cycle gap between requests on every transaction.
